fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares the single write port of the dual-clock stream FIFO between NREQ requesters, all in the wclk domain.
- Grants whole bursts in round-robin order.
- Issues a grant only when the FIFO has room for the entire burst, so a granted burst never stalls on full.
- Tags every written word with the source index so the read side can demultiplex.
- Sits directly in front of the FIFO write interface (w_en/wdata/w_full/wuse).

Parameters:
NREQ, 4, number of requesters (2..16)
TAGW, 2, source tag width; 2^TAGW >= NREQ
DSIZE, 8, payload width per requester
ASIZE, 10, FIFO address width; depth DEPTH = 2^ASIZE
LW, 5, burst length field width
MAXBURST, 16, maximum burst length in words; 1 <= MAXBURST < DEPTH, MAXBURST < 2^LW
GAP, 2, idle cycles after each burst before the next arbitration (covers the wuse register lag)

Ports:
rst_n  in  1  asynchronous active-low reset
wclk  in  1  write-domain clock
req_valid  in  NREQ  per-requester word valid; also acts as the burst request while idle
req_len  in  NREQ*LW  per-requester burst length; held stable while req_valid is high and not yet granted
req_data  in  NREQ*DSIZE  per-requester payload
req_ready  out  NREQ  word accepted in this cycle (combinational)
grant_id  out  TAGW  index of the current or last granted requester
busy  out  1  a burst is in progress (BURST or GAP)
err_len  out  1  sticky: a granted req_len was 0 or greater than MAXBURST
f_wdata  out  TAGW+DSIZE  FIFO write data {tag, payload}
f_w_en  out  1  FIFO write enable (combinational)
f_w_full  in  1  FIFO full
f_wuse  in  ASIZE  FIFO used words, registered, wclk domain

Behaviour:
- Reset values (asynchronous, all outputs):
  - state=IDLE, rr pointer=NREQ-1 (requester 0 has first priority), grant_id=0, busy=0, err_len=0, beat counter=0, gap counter=0.
  - req_ready=0, f_w_en=0, f_wdata=0.
- Free space:
  - free = 0 if f_w_full=1; otherwise DEPTH - f_wuse, computed ASIZE+1 bits wide.
  - f_wuse=0 together with f_w_full=1 means full, not empty.
- Effective length: leff = 1 if req_len=0; MAXBURST if req_len>MAXBURST; else req_len. Either clamped case sets err_len on grant.
- States:
  - IDLE:
    - Candidate c = first i with req_valid[i]=1, searching from rr+1 modulo NREQ.
    - If a candidate exists and leff(c) <= free: register grant_id=c, rr=c, beat counter=leff(c), go to BURST on the next cycle.
    - If leff(c) > free: stay in IDLE and hold c as the candidate. No skipping to a smaller request (head-of-line, starvation-free).
    - No writes occur in IDLE.
  - BURST:
    - req_ready[grant_id] = ~f_w_full; all other req_ready bits are 0.
    - f_w_en = req_valid[grant_id] & ~f_w_full.
    - f_wdata = {grant_id, req_data[grant_id]}; f_wdata=0 when f_w_en=0.
    - Each accepted word decrements the beat counter.
    - Requester deasserting valid mid-burst: wait indefinitely; the burst is held with no timeout.
    - When the last word is accepted (counter=1 and f_w_en=1): go to GAP.
  - GAP: counts GAP cycles with no writes, then returns to IDLE. busy=1 throughout BURST and GAP.
- Latency:
  - A request visible at cycle 0 in IDLE gets its first word written at cycle 1, at the earliest.
  - Back-to-back bursts are separated by GAP+1 cycles.
- f_w_full asserted during BURST: not expected by construction, but must be tolerated. Stall with req_ready=0 and resume when it deasserts.
- A requester holds req_valid across the burst. Its new burst request is the valid level seen after it returns to IDLE.
- Reset asserted mid-burst: immediate return to reset values. Words already written remain in the FIFO. The partial burst is not completed.

Test Plan:
- Single requester 1, req_len=4, empty FIFO: valid at cycle 0 -> f_w_en high at cycles 1–4, f_wdata tag=1, data in order; busy low at cycle 7 (after GAP=2).
- All 4 requesters valid continuously, len=3 -> grant order 0,1,2,3,0; each burst exactly 3 writes; no interleaving of tags within a burst.
- f_wuse=1016 (free=8), requester 0 len=10, requester 1 len=2, rr=3 -> requester 0 is held; requester 1 is not granted until free>=10; no write occurs.
- f_w_full=1 with f_wuse=0 -> free=0, no grant for len=1; after f_w_full=0 and f_wuse=0 -> grant and write.
- req_len=0 -> one word written, err_len=1; req_len=31 -> 16 words written, err_len stays 1 until reset.
- Reset pulse after 2 of 8 words -> all outputs 0 within the same cycle; after release, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the FIFO write port, granting only
// when the whole burst fits and tagging each word with its source index.
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int TAGW     = 2,
   parameter int DSIZE    = 8,
   parameter int ASIZE    = 10,
   parameter int LW       = 5,
   parameter int MAXBURST = 16,
   parameter int GAP      = 2
) (
   input  logic                  rst_n,
   input  logic                  wclk,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*LW-1:0]    req_len,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [TAGW-1:0]       grant_id,
   output logic                  busy,
   output logic                  err_len,
   output logic [TAGW+DSIZE-1:0] f_wdata,
   output logic                  f_w_en,
   input  logic                  f_w_full,
   input  logic [ASIZE-1:0]      f_wuse
);
   localparam int DEPTH = 1 << ASIZE;
   localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
   typedef enum logic [1:0] {IDLE, BURST, GAP_S} state_t;
   state_t            state;
   logic [TAGW-1:0]   rr, cand, idx, hold_id;
   logic              hold_vld, cand_vld, fits, len_bad, bursting;
   logic [LW-1:0]     beats, len_c, leff;
   logic [GW-1:0]     gcnt;
   logic [ASIZE:0]    free;
   assign free = f_w_full ? '0 : (ASIZE+1)'(DEPTH) - {1'b0, f_wuse};
   // A candidate that did not fit stays locked so a smaller request cannot overtake it.
   always_comb begin
      cand_vld = hold_vld & req_valid[hold_id];
      cand     = hold_id;
      idx      = '0;
      if (!cand_vld)
         for (int k = NREQ; k >= 1; k--) begin
            idx = TAGW'((int'(rr) + k) % NREQ);
            if (req_valid[idx]) begin
               cand     = idx;
               cand_vld = 1'b1;
            end
         end
   end
   assign len_c   = req_len[int'(cand)*LW +: LW];
   assign len_bad = (len_c == '0) || (len_c > LW'(MAXBURST));
   assign leff    = (len_c == '0) ? LW'(1) : (len_c > LW'(MAXBURST)) ? LW'(MAXBURST) : len_c;
   assign fits    = cand_vld && ((ASIZE+1)'(leff) <= free);
   assign bursting  = state == BURST;
   assign f_w_en    = bursting & req_valid[grant_id] & ~f_w_full;
   assign req_ready = (bursting & ~f_w_full) ? NREQ'(1) << grant_id : '0;
   assign f_wdata   = f_w_en ? {grant_id, req_data[int'(grant_id)*DSIZE +: DSIZE]} : '0;
   always_ff @(posedge wclk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         rr       <= TAGW'(NREQ - 1);
         grant_id <= '0;
         busy     <= 1'b0;
         err_len  <= 1'b0;
         beats    <= '0;
         gcnt     <= '0;
         hold_vld <= 1'b0;
         hold_id  <= '0;
      end else
         case (state)
            IDLE:
               if (fits) begin
                  state    <= BURST;
                  grant_id <= cand;
                  rr       <= cand;
                  beats    <= leff;
                  busy     <= 1'b1;
                  err_len  <= err_len | len_bad;
                  hold_vld <= 1'b0;
               end else begin
                  hold_vld <= cand_vld;
                  hold_id  <= cand;
               end
            BURST:
               if (f_w_en) begin
                  beats <= beats - LW'(1);
                  if (beats == LW'(1)) begin
                     state <= (GAP == 0) ? IDLE : GAP_S;
                     busy  <= GAP != 0;
                     gcnt  <= GW'(GAP - 1);
                  end
               end
            GAP_S:
               if (gcnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else
                  gcnt <= gcnt - GW'(1);
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: requester agents plus a burst-level round-robin model feeding a
// scoreboard that checks every FIFO write, with directed timing and corner cases.
module tb_fifo_wr_arbiter;
   localparam int NREQ = 4, TAGW = 2, DSIZE = 8, ASIZE = 10, LW = 5, MAXBURST = 16, GAP = 2;
   logic                  rst_n = 1'b0, wclk = 1'b0;
   logic [NREQ-1:0]       req_valid, req_ready, hs;
   logic [NREQ*LW-1:0]    req_len;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [TAGW-1:0]       grant_id;
   logic                  busy, err_len, f_w_en, f_w_full;
   logic [TAGW+DSIZE-1:0] f_wdata, e_mon;
   logic [ASIZE-1:0]      f_wuse;
   int                    checks = 0, fails = 0, wr_count = 0;
   logic [TAGW+DSIZE-1:0] exp_q[$];
   int                    blen[NREQ][8];
   logic [7:0]            bbase[NREQ][8];
   int                    bcnt[NREQ], bidx[NREQ], widx[NREQ];
   int                    m_rr, w0, n;
   bit                    agents_on, rand_env, m_err;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .DSIZE(DSIZE), .ASIZE(ASIZE), .LW(LW),
                     .MAXBURST(MAXBURST), .GAP(GAP)) dut (
      .rst_n(rst_n), .wclk(wclk), .req_valid(req_valid), .req_len(req_len),
      .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
      .err_len(err_len), .f_wdata(f_wdata), .f_w_en(f_w_en), .f_w_full(f_w_full),
      .f_wuse(f_wuse));

   function automatic int leff(int l);
      return (l == 0) ? 1 : (l > MAXBURST) ? MAXBURST : l;
   endfunction

   function automatic bit done();
      for (int i = 0; i < NREQ; i++) if (bidx[i] < bcnt[i]) return 0;
      return exp_q.size() == 0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic sync();
      @(posedge wclk);
      #1;
   endtask

   task automatic clear_agents();
      for (int i = 0; i < NREQ; i++) begin
         bcnt[i] = 0;
         bidx[i] = 0;
         widx[i] = 0;
      end
   endtask

   task automatic add_burst(int i, int l);
      blen[i][bcnt[i]]  = l;
      bbase[i][bcnt[i]] = 8'($urandom);
      bcnt[i]++;
   endtask

   // Whole bursts are served round-robin from the last granted requester onward.
   task automatic model_push();
      int nxt[NREQ];
      int g, r;
      for (int i = 0; i < NREQ; i++) nxt[i] = bidx[i];
      do begin
         g = -1;
         for (int k = 1; k <= NREQ; k++) begin
            r = (m_rr + k) % NREQ;
            if (g < 0 && nxt[r] < bcnt[r]) g = r;
         end
         if (g >= 0) begin
            for (int j = 0; j < leff(blen[g][nxt[g]]); j++)
               exp_q.push_back({TAGW'(g), 8'(int'(bbase[g][nxt[g]]) + j)});
            if (blen[g][nxt[g]] == 0 || blen[g][nxt[g]] > MAXBURST) m_err = 1;
            nxt[g]++;
            m_rr = g;
         end
      end while (g >= 0);
   endtask

   task automatic drive_agents();
      bit pend;
      for (int i = 0; i < NREQ; i++) begin
         pend = bidx[i] < bcnt[i];
         req_valid[i] = pend && !(rand_env && widx[i] > 0 && $urandom_range(0, 3) == 0);
         req_len[i*LW +: LW] = pend ? LW'(blen[i][bidx[i]]) : '0;
         req_data[i*DSIZE +: DSIZE] = pend ? 8'(int'(bbase[i][bidx[i]]) + widx[i]) : '0;
      end
   endtask

   task automatic start();
      model_push();
      agents_on = 1;
      drive_agents();
   endtask

   task automatic cycle();
      @(negedge wclk);
      hs = req_ready & req_valid;
      @(posedge wclk);
      #1;
      if (agents_on) begin
         for (int i = 0; i < NREQ; i++)
            if (hs[i] && bidx[i] < bcnt[i]) begin
               widx[i]++;
               if (widx[i] == leff(blen[i][bidx[i]])) begin
                  bidx[i]++;
                  widx[i] = 0;
               end
            end
         drive_agents();
      end
      if (rand_env) begin
         f_w_full = $urandom_range(0, 7) == 0;
         f_wuse = ($urandom_range(0, 3) == 0) ? ASIZE'($urandom_range(1000, 1023))
                                              : ASIZE'($urandom_range(0, 900));
      end
   endtask

   task automatic wait_done(string name, int limit);
      int k = 0;
      while (!(done() && !busy) && k < limit) begin
         cycle();
         k++;
      end
      chk({name, "_timeout"}, 32'(k < limit), 1);
   endtask

   task automatic do_reset();
      sync();
      rst_n = 0;
      agents_on = 0;
      rand_env = 0;
      f_w_full = 0;
      f_wuse = '0;
      clear_agents();
      drive_agents();
      exp_q.delete();
      m_rr = NREQ - 1;
      m_err = 0;
      sync();
      rst_n = 1;
   endtask

   initial begin
      fork
         forever begin
            @(negedge wclk);
            if (f_w_en) begin
               wr_count++;
               checks++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL sb_write: got %0h, expected no write", f_wdata);
               end else begin
                  e_mon = exp_q.pop_front();
                  if (f_wdata !== e_mon) begin
                     fails++;
                     $display("FAIL sb_write: got %0h, expected %0h", f_wdata, e_mon);
                  end
               end
            end
         end
      join_none
      m_rr = NREQ - 1;
      rand_env = 0;
      agents_on = 0;
      clear_agents();
      req_valid = '1;
      req_len = {NREQ{LW'(4)}};
      req_data = '1;
      f_w_full = 0;
      f_wuse = '0;
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err_len", 32'(err_len), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_f_w_en", 32'(f_w_en), 0);
      chk("rst_f_wdata", 32'(f_wdata), 0);
      drive_agents();
      sync();
      rst_n = 1;
      // single burst latency: writes in cycles 1..4, busy clear at cycle 7
      add_burst(1, 4);
      start();
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin
            cycle();
            #1;
         end
         chk("lat_f_w_en", 32'(f_w_en), 32'(c >= 1 && c <= 4));
         chk("lat_busy", 32'(busy), 32'(c >= 1 && c <= 6));
         if (c == 1) chk("lat_grant_id", 32'(grant_id), 1);
      end
      wait_done("lat", 50);
      // all four requesting, len 3
      do_reset();
      add_burst(0, 3); add_burst(0, 3); add_burst(1, 3); add_burst(2, 3); add_burst(3, 3);
      w0 = wr_count;
      start();
      wait_done("rr", 300);
      chk("rr_words", 32'(wr_count - w0), 15);
      chk("rr_last_grant", 32'(grant_id), 0);
      // head-of-line hold with free=8
      do_reset();
      f_wuse = ASIZE'(1016);
      add_burst(0, 10); add_burst(1, 2);
      w0 = wr_count;
      start();
      repeat (20) cycle();
      chk("hold_nowrite", 32'(wr_count - w0), 0);
      chk("hold_busy", 32'(busy), 0);
      f_wuse = ASIZE'(1015);
      repeat (5) cycle();
      chk("hold_free9_nowrite", 32'(wr_count - w0), 0);
      f_wuse = ASIZE'(1014);
      wait_done("hold", 200);
      chk("hold_words", 32'(wr_count - w0), 12);
      // full with wuse=0 means no room
      f_wuse = '0;
      f_w_full = 1;
      add_burst(2, 1);
      w0 = wr_count;
      start();
      repeat (10) cycle();
      chk("full_nowrite", 32'(wr_count - w0), 0);
      chk("full_busy", 32'(busy), 0);
      f_w_full = 0;
      wait_done("full", 50);
      chk("full_words", 32'(wr_count - w0), 1);
      // length clamping and sticky error
      chk("err_before", 32'(err_len), 0);
      add_burst(3, 0);
      w0 = wr_count;
      start();
      wait_done("len0", 50);
      chk("len0_words", 32'(wr_count - w0), 1);
      chk("len0_err", 32'(err_len), 1);
      add_burst(0, 31);
      w0 = wr_count;
      start();
      wait_done("len31", 100);
      chk("len31_words", 32'(wr_count - w0), 16);
      chk("len31_err", 32'(err_len), 1);
      // reset after 2 of 8 words
      do_reset();
      chk("err_cleared", 32'(err_len), 0);
      add_burst(0, 8);
      w0 = wr_count;
      start();
      n = 0;
      while (wr_count - w0 < 2 && n < 50) begin
         cycle();
         n++;
      end
      chk("mid_reach", 32'(n < 50), 1);
      #1 rst_n = 0;
      #1;
      chk("mid_f_w_en", 32'(f_w_en), 0);
      chk("mid_req_ready", 32'(req_ready), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_grant_id", 32'(grant_id), 0);
      chk("mid_f_wdata", 32'(f_wdata), 0);
      chk("mid_words", 32'(wr_count - w0), 2);
      agents_on = 0;
      clear_agents();
      drive_agents();
      exp_q.delete();
      m_rr = NREQ - 1;
      m_err = 0;
      sync();
      rst_n = 1;
      add_burst(3, 2); add_burst(1, 2); add_burst(0, 2);
      start();
      #1;
      cycle();
      #1;
      chk("mid_first_grant", 32'(grant_id), 0);
      wait_done("mid_after", 100);
      chk("mid_last_grant", 32'(grant_id), 3);
      // randomized rounds with stalls, full pulses and valid gaps
      do_reset();
      for (int r = 0; r < 3; r++) begin
         rand_env = 1;
         for (int i = 0; i < NREQ; i++)
            repeat ($urandom_range(0, 2)) add_burst(i, $urandom_range(0, 20));
         start();
         wait_done("rand", 20000);
         rand_env = 0;
         f_w_full = 0;
         f_wuse = '0;
         chk("rand_err_len", 32'(err_len), 32'(m_err));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
